// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: issues one instruction-memory request per PC, holds the
// returned word for the core, and redirects to next_PC when the core consumes it.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] PC_plus4,
  input  logic        inst_ready,
  input  logic [31:0] next_PC,
  output logic        misalign,
  output logic [31:0] retire_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic        capture;
  logic        consume;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the values from before the edge, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    consume    = 1'b0;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (imem_ack) begin
          capture    = 1'b1;
          state_next = VALID;
        end
      end
      VALID: begin
        if (inst_ready) begin
          consume    = 1'b1;
          state_next = (next_PC[1:0] == 2'b00) ? FETCH : HALT;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // Acks outside FETCH and ready outside VALID never raise capture/consume.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc           <= RESET_PC;
      inst         <= 32'h0000_0000;
      inst_pc      <= RESET_PC;
      misalign     <= 1'b0;
      retire_count <= 32'h0000_0000;
    end else begin
      if (capture) begin
        inst    <= imem_rdata;
        inst_pc <= pc;
      end
      if (consume) begin
        pc           <= next_PC;
        retire_count <= retire_count + 32'd1;
        if (next_PC[1:0] != 2'b00) begin
          misalign <= 1'b1;
        end
      end
    end
  end

  assign imem_req   = (state == FETCH);
  assign imem_addr  = pc;
  assign inst_valid = (state == VALID);
  assign PC_plus4   = inst_pc + 32'd4;

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset; bits [1:0] are zero.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  instruction-memory request valid.
REQ-005 imem_addr  output  32  fetch address; equals the current PC.
REQ-006 imem_ack  input  1  memory response strobe; imem_rdata is valid in the same cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 inst_valid  output  1  instruction held for the core.
REQ-009 inst  output  32  held instruction word.
REQ-010 inst_pc  output  32  address of the held instruction.
REQ-011 PC_plus4  output  32  inst_pc + 4, supplied to next-PC selection.
REQ-012 inst_ready  input  1  core consumes the held instruction this cycle.
REQ-013 next_PC  input  32  selected successor PC; sampled only on the consume cycle.
REQ-014 misalign  output  1  sticky error flag: next_PC had nonzero bits [1:0].
REQ-015 retire_count  output  32  count of consumed instructions.

Function
REQ-016 The block SHALL implement four states: IDLE, FETCH, VALID, HALT.
REQ-017 IDLE SHALL move unconditionally to FETCH on the first clock edge after reset deasserts.
REQ-018 In FETCH, imem_req SHALL be 1 and imem_addr SHALL hold the PC stable until imem_ack.
REQ-019 When imem_ack=1 in FETCH, the block SHALL capture imem_rdata into inst and enter VALID.
  - inst_valid is 1 in the next cycle: one-cycle ack-to-valid latency.
REQ-020 imem_ack SHALL be ignored in IDLE, VALID and HALT.
REQ-021 In VALID, imem_req SHALL be 0, and inst_valid, inst and inst_pc SHALL stay stable until inst_ready=1.
REQ-022 On a cycle with inst_valid=1 and inst_ready=1, the block SHALL:
  - load PC <= next_PC;
  - increment retire_count;
  - enter FETCH if next_PC[1:0]==0, otherwise set misalign=1 and enter HALT.
REQ-023 Handshake to next request: imem_req SHALL reassert in the cycle after the consume cycle, with imem_addr equal to the new PC.
REQ-024 inst_ready while inst_valid=0 SHALL have no effect.
REQ-025 HALT SHALL issue no requests, and SHALL hold inst_valid=0 and misalign=1 until reset.
REQ-026 PC_plus4 SHALL be inst_pc + 32'd4, truncated modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-027 retire_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-028 inst_pc SHALL equal the PC latched with the fetch; the PC changes only on a consume cycle.

Reset
REQ-029 Asserting reset SHALL immediately set:
  - state=IDLE, PC=RESET_PC;
  - imem_req=0, inst_valid=0, inst=0, misalign=0, retire_count=0.
REQ-030 Reset asserted during an outstanding FETCH SHALL abandon the request; a late imem_ack after reset SHALL be ignored (state is IDLE).
REQ-031 After reset, imem_addr SHALL read RESET_PC and PC_plus4 SHALL read RESET_PC+4.

Verification
REQ-032 Reset release with RESET_PC=0, imem_ack=1 after 2 cycles, rdata=32'h00500093 -> imem_req high with addr 0 from cycle 1; inst_valid=1 with inst=32'h00500093, inst_pc=0, PC_plus4=4.
REQ-033 inst_ready held 0 for 5 cycles, then 1 with next_PC=32'h0000_0040 -> inst stable for 5 cycles; next cycle imem_req=1, imem_addr=32'h40; retire_count=1.
REQ-034 Consume with next_PC=32'h0000_0042 -> misalign=1, state HALT, no further imem_req, even with imem_ack pulsed.
REQ-035 Reset pulsed while imem_req=1 at addr 32'h80, imem_ack arriving one cycle after reset drops -> the ack is ignored; the fetch restarts at RESET_PC.
REQ-036 inst_pc=32'hFFFF_FFFC -> PC_plus4=0; consume with next_PC=0 -> fetch at addr 0 and no misalign.
REQ-037 imem_ack pulsed while in VALID with different rdata -> inst unchanged.
